// File: rtl/md5_block_padder.sv
// MD5 padding stage: packs 32-bit LE message words into 512-bit blocks and appends 0x80, zero fill and 64-bit bit length.
// Optional MD5_PADDER_STATS_EN adds stat_blocks / stat_msgs handshake counters.
module md5_block_padder #(
    parameter int CNT_WIDTH = 61
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_last
`ifdef MD5_PADDER_STATS_EN
    ,
    output logic [31:0]  stat_blocks,
    output logic [31:0]  stat_msgs
`endif
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_PAD  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [3:0]             word_idx, idx_nxt;
    logic [CNT_WIDTH-1:0]   byte_cnt, cnt_nxt;
    logic                   marker_done, mk_nxt;
    logic                   msg_end, end_nxt;
    logic [511:0]           blk_q, blk_nxt;
    logic                   blk_last_q, last_nxt;
    logic                   in_fire, out_fire;
    logic [8:0]             wsel;
    logic [2:0]             nbytes;
    logic [63:0]            bit_len;

    // Invalid trailing bytes of the final word are replaced by the marker and zero fill.
    function automatic logic [31:0] pad_last(input logic [31:0] d, input logic [1:0] nb);
        case (nb)
            2'd1:    pad_last = {16'h0000, 8'h80, d[7:0]};
            2'd2:    pad_last = {8'h00, 8'h80, d[15:0]};
            2'd3:    pad_last = {8'h80, d[23:0]};
            default: pad_last = d;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_FILL;
            word_idx    <= 4'd0;
            byte_cnt    <= '0;
            marker_done <= 1'b0;
            msg_end     <= 1'b0;
            blk_q       <= '0;
            blk_last_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            word_idx    <= idx_nxt;
            byte_cnt    <= cnt_nxt;
            marker_done <= mk_nxt;
            msg_end     <= end_nxt;
            blk_q       <= blk_nxt;
            blk_last_q  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = word_idx;
        cnt_nxt   = byte_cnt;
        mk_nxt    = marker_done;
        end_nxt   = msg_end;
        blk_nxt   = blk_q;
        last_nxt  = blk_last_q;
        in_ready  = (state == S_FILL);
        blk_valid = (state == S_OUT);
        in_fire   = in_valid && in_ready;
        out_fire  = blk_valid && blk_ready;
        wsel      = {word_idx, 5'd0};
        nbytes    = (in_bytes == 2'd0) ? 3'd4 : {1'b0, in_bytes};
        bit_len   = 64'({byte_cnt, 3'b000});

        case (state)
            S_FILL: begin
                if (in_fire) begin
                    if (in_last) begin
                        blk_nxt[wsel +: 32] = pad_last(in_data, in_bytes);
                        cnt_nxt = byte_cnt + CNT_WIDTH'(nbytes);
                        mk_nxt  = (in_bytes != 2'd0);
                        end_nxt = 1'b1;
                    end else begin
                        blk_nxt[wsel +: 32] = in_data;
                        cnt_nxt = byte_cnt + CNT_WIDTH'(3'd4);
                    end
                    if (word_idx == 4'd15) begin
                        state_nxt = S_OUT;
                        last_nxt  = 1'b0;
                        idx_nxt   = 4'd0;
                    end else begin
                        idx_nxt = word_idx + 4'd1;
                        if (in_last) state_nxt = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (marker_done && word_idx == 4'd14) begin
                    blk_nxt[14*32 +: 32] = bit_len[31:0];
                    blk_nxt[15*32 +: 32] = bit_len[63:32];
                    state_nxt = S_OUT;
                    last_nxt  = 1'b1;
                end else begin
                    blk_nxt[wsel +: 32] = marker_done ? 32'h0000_0000 : 32'h0000_0080;
                    mk_nxt = 1'b1;
                    if (word_idx == 4'd15) begin
                        state_nxt = S_OUT;
                        last_nxt  = 1'b0;
                        idx_nxt   = 4'd0;
                    end else begin
                        idx_nxt = word_idx + 4'd1;
                    end
                end
            end
            S_OUT: begin
                if (out_fire) begin
                    if (blk_last_q) begin
                        state_nxt = S_FILL;
                        idx_nxt   = 4'd0;
                        cnt_nxt   = '0;
                        mk_nxt    = 1'b0;
                        end_nxt   = 1'b0;
                        blk_nxt   = '0;
                    end else if (msg_end) begin
                        // Length did not fit: a second, padding-only block follows.
                        state_nxt = S_PAD;
                    end else begin
                        state_nxt = S_FILL;
                    end
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    assign blk_data = blk_q;
    assign blk_last = blk_last_q;

`ifdef MD5_PADDER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_blocks <= 32'd0;
            stat_msgs   <= 32'd0;
        end else if (out_fire) begin
            stat_blocks <= stat_blocks + 32'd1;
            if (blk_last_q) stat_msgs <= stat_msgs + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_md5_block_padder.sv
// Self-checking bench for md5_block_padder: byte-level MD5 padding model, directed and randomized messages.
module tb_md5_block_padder;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_last = 1'b0;
    logic [1:0]   in_bytes = '0;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic         blk_last;
`ifdef MD5_PADDER_STATS_EN
    logic [31:0]  stat_blocks;
    logic [31:0]  stat_msgs;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0]  msg_w[$];
    logic [1:0]   last_code;
    logic [511:0] exp_blk[$];
    logic         exp_last[$];
    logic [511:0] got_blk[$];
    logic         got_last[$];
    logic         drv_to, col_to;
    logic [511:0] abc_blk;

    md5_block_padder dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_last  (blk_last)
`ifdef MD5_PADDER_STATS_EN
        ,
        .stat_blocks (stat_blocks),
        .stat_msgs   (stat_msgs)
`endif
    );

    always #5 clk = ~clk;

    // Reference: MD5 padding on a plain byte list, then split into 16 LE words per block.
    function automatic void build_expected();
        byte unsigned p[$];
        int           n;
        int           k;
        logic [63:0]  bl;
        logic [511:0] b;
        int           base;
        n = (last_code == 2'd0) ? 4 : int'(last_code);
        for (int i = 0; i < msg_w.size(); i++) begin
            k = (i == msg_w.size() - 1) ? n : 4;
            for (int j = 0; j < k; j++) p.push_back(msg_w[i][8*j +: 8]);
        end
        bl = 64'(p.size()) << 3;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int j = 0; j < 8; j++) p.push_back(bl[8*j +: 8]);
        exp_blk.delete();
        exp_last.delete();
        for (int bn = 0; bn < p.size() / 64; bn++) begin
            b = '0;
            for (int w = 0; w < 16; w++) begin
                base = bn * 64 + w * 4;
                b[32*w +: 32] = {p[base+3], p[base+2], p[base+1], p[base]};
            end
            exp_blk.push_back(b);
            exp_last.push_back(bn == p.size() / 64 - 1);
        end
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        blk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_msg(input bit rnd);
        int wc;
        drv_to = 1'b0;
        for (int i = 0; i < msg_w.size(); i++) begin
            if (rnd) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = msg_w[i];
            in_last  = (i == msg_w.size() - 1);
            in_bytes = in_last ? last_code : 2'($urandom);
            wc = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                wc++;
                if (wc > 2000) begin
                    drv_to = 1'b1;
                    in_valid = 1'b0;
                    in_last = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic collect(input int nblk, input bit rnd);
        int cyc = 0;
        col_to = 1'b0;
        got_blk.delete();
        got_last.delete();
        while (got_blk.size() < nblk) begin
            @(posedge clk);
            #1 blk_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (blk_valid && blk_ready) begin
                got_blk.push_back(blk_data);
                got_last.push_back(blk_last);
            end
            cyc++;
            if (cyc > 5000) begin
                col_to = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 blk_ready = 1'b0;
    endtask

    task automatic xfer(input bit rv, input bit rr);
        fork
            drive_msg(rv);
            collect(exp_blk.size(), rr);
        join
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_blk_valid got %b exp 0", blk_valid); end
        checks++; if (blk_last !== 1'b0) begin errors++; $display("FAIL reset_blk_last got %b exp 0", blk_last); end
        checks++; if (blk_data !== '0) begin errors++; $display("FAIL reset_blk_data got %h exp 0", blk_data); end
    endtask

    task automatic test_abc();
        int lat = 0;
        int wc = 0;
        msg_w = '{32'h00636261};
        last_code = 2'd3;
        build_expected();
        in_valid = 1'b1; in_data = 32'h00636261; in_last = 1'b1; in_bytes = 2'd3;
        while (wc < 100) begin
            @(negedge clk);
            if (in_ready) break;
            wc++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
        while (!blk_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        checks++; if (lat !== 14) begin errors++; $display("FAIL abc_latency got %0d exp 14", lat); end
        collect(1, 1'b0);
        checks++; if (col_to !== 1'b0) begin errors++; $display("FAIL abc_timeout got %b exp 0", col_to); end
        if (got_blk.size() == 1) begin
            checks++; if (got_blk[0] !== abc_blk) begin errors++; $display("FAIL abc_data got %h exp %h", got_blk[0], abc_blk); end
            checks++; if (got_blk[0] !== exp_blk[0]) begin errors++; $display("FAIL abc_model got %h exp %h", got_blk[0], exp_blk[0]); end
            checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL abc_last got %b exp 1", got_last[0]); end
        end
    endtask

    task automatic test_full_words(input int nw, input logic [31:0] len_word);
        msg_w.delete();
        for (int i = 0; i < nw; i++) msg_w.push_back($urandom);
        last_code = 2'd0;
        build_expected();
        xfer(1'b0, 1'b0);
        checks++; if (got_blk.size() !== 2) begin errors++; $display("FAIL full%0d_count got %0d exp 2", nw, got_blk.size()); end
        if (got_blk.size() == 2) begin
            for (int i = 0; i < 2; i++) begin
                checks++; if (got_blk[i] !== exp_blk[i]) begin errors++; $display("FAIL full%0d_blk%0d got %h exp %h", nw, i, got_blk[i], exp_blk[i]); end
                checks++; if (got_last[i] !== (i == 1)) begin errors++; $display("FAIL full%0d_last%0d got %b exp %b", nw, i, got_last[i], i == 1); end
            end
            checks++; if (got_blk[1][14*32 +: 32] !== len_word) begin errors++; $display("FAIL full%0d_len got %h exp %h", nw, got_blk[1][14*32 +: 32], len_word); end
            if (nw == 14) begin
                checks++; if (got_blk[0][14*32 +: 32] !== 32'h80) begin errors++; $display("FAIL full14_marker got %h exp 00000080", got_blk[0][14*32 +: 32]); end
            end else begin
                checks++; if (got_blk[1][31:0] !== 32'h80) begin errors++; $display("FAIL full16_marker got %h exp 00000080", got_blk[1][31:0]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [511:0] hd;
        logic         hl;
        int           wc = 0;
        msg_w = '{32'hAB636261};
        last_code = 2'd3;
        blk_ready = 1'b0;
        drive_msg(1'b0);
        while (wc < 100) begin
            @(negedge clk);
            if (blk_valid) break;
            wc++;
        end
        checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_rise got %b exp 1", blk_valid); end
        hd = blk_data;
        hl = blk_last;
        repeat (5) begin
            @(negedge clk);
            checks++; if (blk_data !== hd || blk_last !== hl || blk_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold got %h/%b/%b exp %h/%b/1", blk_data, blk_last, blk_valid, hd, hl);
            end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        end
        checks++; if (hd !== abc_blk) begin errors++; $display("FAIL bp_data got %h exp %h", hd, abc_blk); end
        @(posedge clk);
        #1 blk_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_transfer got valid %b ready %b exp 0 1", blk_valid, in_ready);
        end
        blk_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_last = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_data = $urandom | 32'h1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++; if (blk_data !== '0 || blk_valid !== 1'b0 || blk_last !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_async got data %h valid %b last %b ready %b exp 0 0 0 1", blk_data, blk_valid, blk_last, in_ready);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        msg_w = '{32'h00636261};
        last_code = 2'd3;
        build_expected();
        xfer(1'b0, 1'b0);
        checks++; if (got_blk.size() !== 1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", got_blk.size()); end
        if (got_blk.size() == 1) begin
            checks++; if (got_blk[0] !== abc_blk || got_last[0] !== 1'b1) begin
                errors++; $display("FAIL rstmid_abc got %h/%b exp %h/1", got_blk[0], got_last[0], abc_blk);
            end
        end
    endtask

    task automatic test_random();
        int nw;
        for (int m = 0; m < 10; m++) begin
            nw = $urandom_range(1, 40);
            msg_w.delete();
            for (int i = 0; i < nw; i++) msg_w.push_back($urandom);
            last_code = 2'($urandom);
            build_expected();
            xfer(1'b1, 1'b1);
            checks++; if (drv_to !== 1'b0 || col_to !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout got %b%b exp 00", m, drv_to, col_to); end
            checks++; if (got_blk.size() !== exp_blk.size()) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", m, got_blk.size(), exp_blk.size()); end
            for (int i = 0; i < exp_blk.size() && i < got_blk.size(); i++) begin
                checks++; if (got_blk[i] !== exp_blk[i] || got_last[i] !== exp_last[i]) begin
                    errors++; $display("FAIL rand%0d_blk%0d got %h/%b exp %h/%b", m, i, got_blk[i], got_last[i], exp_blk[i], exp_last[i]);
                end
            end
        end
    endtask

`ifdef MD5_PADDER_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++; if (stat_blocks !== 32'd0 || stat_msgs !== 32'd0) begin errors++; $display("FAIL stats_reset got %0d %0d exp 0 0", stat_blocks, stat_msgs); end
        msg_w = '{32'h00636261};
        last_code = 2'd3;
        build_expected();
        xfer(1'b0, 1'b0);
        msg_w.delete();
        for (int i = 0; i < 14; i++) msg_w.push_back($urandom);
        last_code = 2'd0;
        build_expected();
        xfer(1'b0, 1'b0);
        checks++; if (stat_blocks !== 32'd3) begin errors++; $display("FAIL stat_blocks got %0d exp 3", stat_blocks); end
        checks++; if (stat_msgs !== 32'd2) begin errors++; $display("FAIL stat_msgs got %0d exp 2", stat_msgs); end
    endtask
`endif

    initial begin
        abc_blk = '0;
        abc_blk[31:0] = 32'h80636261;
        abc_blk[14*32 +: 32] = 32'h00000018;
        test_reset();
        test_abc();
        test_full_words(14, 32'h000001C0);
        test_full_words(16, 32'h00000200);
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef MD5_PADDER_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
